// File: rtl/key_repeat.sv
// key_repeat: keyboard auto-repeat controller producing key events on valid/ready
// Feature macro KEY_REPEAT_AUTO_EN enables delay/rate repeats; press events only otherwise.
module key_repeat #(
   parameter int DELAY_TICKS = 50,
   parameter int RATE_TICKS  = 3,
   parameter int CODE_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_down,
   input  logic [CODE_WIDTH-1:0] key_code,
   output logic                  event_valid,
   output logic [CODE_WIDTH-1:0] event_code,
   input  logic                  event_ready,
   output logic                  timer_clear,
   output logic                  timer_enabled,
   input  logic                  timer_finished
);
`ifdef KEY_REPEAT_AUTO_EN
   localparam int MAX_TICKS = DELAY_TICKS > RATE_TICKS ? DELAY_TICKS : RATE_TICKS;
   localparam int TW = $clog2(MAX_TICKS + 1);
   typedef enum logic [1:0] {IDLE, SEND, DELAY, REPEAT} state_t;
   state_t state_q, state_d, after_send_q, after_send_d;
   logic [TW-1:0] ticks_q, ticks_d;
   logic terminal;
`else
   typedef enum logic {IDLE, SEND} state_t;
   state_t state_q, state_d;
   logic unused_finished;
`endif
   logic key_prev_q;
   logic [CODE_WIDTH-1:0] code_q, code_d;
   logic press, handshake;
   assign press = key_down && !key_prev_q;
   assign event_valid = state_q == SEND;
   assign event_code = event_valid ? code_q : '0;
   assign handshake = event_valid && event_ready;
`ifdef KEY_REPEAT_AUTO_EN
   assign timer_enabled = state_q == DELAY || state_q == REPEAT;
   assign timer_clear = !timer_enabled || timer_finished;
   assign terminal = state_q == DELAY ? ticks_q == TW'(DELAY_TICKS) : ticks_q == TW'(RATE_TICKS);
   // next state: release beats code change beats interval expiry while counting
   always_comb begin
      state_d = state_q;
      code_d = code_q;
      after_send_d = after_send_q;
      ticks_d = ticks_q;
      if (state_q == IDLE) begin
         if (press) begin
            state_d = SEND;
            code_d = key_code;
            after_send_d = DELAY;
         end
      end else if (state_q == SEND) begin
         if (handshake) begin
            state_d = key_down ? after_send_q : IDLE;
            ticks_d = '0;
         end
      end else begin
         ticks_d = ticks_q + TW'(timer_finished);
         if (!key_down) begin
            state_d = IDLE;
         end else if (key_code != code_q) begin
            state_d = SEND;
            code_d = key_code;
            after_send_d = DELAY;
         end else if (terminal) begin
            state_d = SEND;
            after_send_d = REPEAT;
         end
      end
   end
   // state, latched code, interval bookkeeping and key level history
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         after_send_q <= DELAY;
         ticks_q <= '0;
         code_q <= '0;
         key_prev_q <= 1'b0;
      end else begin
         state_q <= state_d;
         after_send_q <= after_send_d;
         ticks_q <= ticks_d;
         code_q <= code_d;
         key_prev_q <= key_down;
      end
   end
`else
   assign timer_enabled = 1'b0;
   assign timer_clear = 1'b1;
   assign unused_finished = timer_finished;
   // next state: one event per press, a held key never re-triggers
   always_comb begin
      state_d = state_q;
      code_d = code_q;
      if (state_q == IDLE && press) begin
         state_d = SEND;
         code_d = key_code;
      end else if (state_q == SEND && handshake) begin
         state_d = IDLE;
      end
   end
   // state, latched code and key level history
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         code_q <= '0;
         key_prev_q <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q <= code_d;
         key_prev_q <= key_down;
      end
   end
`endif
endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: self-checking bench for key_repeat with a period-4 tick timer
module tb_key_repeat;
   localparam int D = 3;
   localparam int R = 2;
   localparam int P = 4;
   logic clk = 1'b0;
   logic reset, key_down, event_ready;
   logic [7:0] key_code;
   logic event_valid, timer_clear, timer_enabled, timer_finished;
   logic [7:0] event_code;
   logic [1:0] t_cnt = 2'd0;
   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit started = 0;
   int n_acc = 0;
   int hs_q[$];
   int rise_q[$];
   logic [7:0] acc_code;
   bit v_prev = 0;
   bit m_valid = 0;
   bit m_rep = 0;
   bit m_prev = 0;
   logic [7:0] m_code = 8'h0;
   int m_wait = 0;

   key_repeat #(.DELAY_TICKS(D), .RATE_TICKS(R), .CODE_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .key_down(key_down), .key_code(key_code),
      .event_valid(event_valid), .event_code(event_code), .event_ready(event_ready),
      .timer_clear(timer_clear), .timer_enabled(timer_enabled), .timer_finished(timer_finished)
   );

   always #5 clk = ~clk;

   // external timer: finishes on every P-th enabled cycle, clear wins
   assign timer_finished = timer_enabled && t_cnt == 2'(P - 1);
   always @(posedge clk) t_cnt <= timer_clear ? 2'd0 : timer_enabled ? t_cnt + 2'd1 : t_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic int qat(input int q[$], input int i);
      return i < q.size() ? q[i] : -100000;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input int target, input int lim, input string nm);
      for (int i = 0; i < lim && hs_q.size() < target; i++) step(1);
      chk(nm, hs_q.size() >= target, 1);
   endtask

   task automatic wait_valid(input int lim, input string nm);
      for (int i = 0; i < lim && !event_valid; i++) step(1);
      chk(nm, event_valid, 1);
   endtask

   task automatic clear_log();
      hs_q.delete();
      rise_q.delete();
   endtask

   // DUT-side observation: accepted events and valid rise edges
   always @(posedge clk) begin
      cyc <= cyc + 1;
      started <= 1'b1;
      if (!reset && event_valid && event_ready) begin
         n_acc++;
         hs_q.push_back(cyc);
         acc_code = event_code;
      end
   end
   always @(negedge clk) begin
      if (event_valid === 1'b1 && !v_prev) rise_q.push_back(cyc - 1);
      v_prev = event_valid === 1'b1;
   end

   // model: an event is pending, or a cycle countdown runs to the next repeat
   always @(posedge clk) begin
      if (reset) begin
         m_valid = 0;
         m_wait = 0;
         m_prev = 0;
         m_code = 8'h0;
      end else begin
         if (m_valid) begin
            if (event_ready) begin
               m_valid = 0;
`ifdef KEY_REPEAT_AUTO_EN
               m_wait = key_down ? (m_rep ? R : D) * P + 1 : 0;
`endif
            end
         end else if (m_wait > 0) begin
            if (!key_down) m_wait = 0;
            else if (key_code != m_code) begin
               m_wait = 0;
               m_valid = 1;
               m_code = key_code;
               m_rep = 0;
            end else begin
               m_wait--;
               if (m_wait == 0) begin
                  m_valid = 1;
                  m_rep = 1;
               end
            end
         end else if (key_down && !m_prev) begin
            m_valid = 1;
            m_code = key_code;
            m_rep = 0;
         end
         m_prev = key_down;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk("cyc_valid", event_valid, m_valid);
         chk("cyc_code", event_code, m_valid ? m_code : 8'h0);
         chk("cyc_enabled", timer_enabled, m_wait > 0);
         chk("cyc_clear", timer_clear, !(m_wait > 0) || timer_finished);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int t0, bad, base;
      reset = 1;
      key_down = 0;
      key_code = 8'h0;
      event_ready = 0;
      step(3);
      chk("rst_valid", event_valid, 0);
      chk("rst_code", event_code, 0);
      chk("rst_enabled", timer_enabled, 0);
      chk("rst_clear", timer_clear, 1);
      reset = 0;
      step(2);
`ifdef KEY_REPEAT_AUTO_EN
      clear_log();
      event_ready = 1;
      key_code = 8'h41;
      key_down = 1;
      t0 = cyc;
      step(1);
      chk("s1_press_valid", event_valid, 1);
      chk("s1_press_code", event_code, 8'h41);
      step(60);
      chk("s1_rise_count", rise_q.size(), 6);
      chk("s1_press_edge", qat(rise_q, 0) - t0, 0);
      chk("s1_first_repeat", qat(rise_q, 1) - qat(hs_q, 0), 13);
      chk("s1_second_repeat", qat(rise_q, 2) - qat(hs_q, 1), 9);
      chk("s1_five_in_49", qat(rise_q, 5) - qat(rise_q, 1) <= 49, 1);
      chk("s1_code", acc_code, 8'h41);
      key_down = 0;
      step(20);
      clear_log();
      key_down = 1;
      wait_hs(1, 5, "s2_press_hs");
      event_ready = 0;
      wait_valid(20, "s2_repeat_seen");
      chk("s2_first_repeat", (cyc - 1) - qat(hs_q, 0), 13);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (event_valid !== 1'b1 || event_code !== 8'h41 || timer_enabled !== 1'b0) bad++;
         step(1);
      end
      chk("s2_stall_stable", bad, 0);
      chk("s2_no_extra_acc", hs_q.size(), 1);
      event_ready = 1;
      step(1);
      chk("s2_one_repeat", hs_q.size(), 2);
      wait_valid(15, "s2_next_seen");
      chk("s2_next_repeat", (cyc - 1) - qat(hs_q, 1), 9);
      key_down = 0;
      step(20);
      clear_log();
      key_down = 1;
      wait_hs(1, 5, "s3_press_hs");
      step(5);
      key_down = 0;
      step(1);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (timer_clear !== 1'b1 || event_valid !== 1'b0) bad++;
         step(1);
      end
      chk("s3_clear_steady", bad, 0);
      chk("s3_no_events", rise_q.size(), 1);
      clear_log();
      key_code = 8'h41;
      key_down = 1;
      wait_hs(2, 30, "s4_repeat_hs");
      step(3);
      key_code = 8'h42;
      t0 = cyc;
      step(1);
      chk("s4_new_valid", event_valid, 1);
      chk("s4_new_code", event_code, 8'h42);
      wait_hs(3, 5, "s4_new_hs");
      chk("s4_new_edge", qat(hs_q, 2) - t0, 1);
      wait_valid(20, "s4_repeat_seen");
      chk("s4_repeat_delay", (cyc - 1) - qat(hs_q, 2), 13);
      chk("s4_repeat_code", event_code, 8'h42);
      key_down = 0;
      step(20);
`else
      clear_log();
      event_ready = 1;
      key_code = 8'h41;
      key_down = 1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (i == 50) key_code = 8'h42;
         step(1);
         if (timer_enabled !== 1'b0) bad++;
      end
      chk("n_one_event", hs_q.size(), 1);
      chk("n_code", acc_code, 8'h41);
      chk("n_enabled_low", bad, 0);
      key_down = 0;
      step(2);
      key_code = 8'h43;
      key_down = 1;
      step(1);
      chk("n_repress_valid", event_valid, 1);
      chk("n_repress_code", event_code, 8'h43);
      step(2);
      chk("n_second_event", hs_q.size(), 2);
      key_down = 0;
      step(5);
`endif
      clear_log();
      event_ready = 0;
      key_code = 8'h55;
      key_down = 1;
      step(1);
      chk("s5_valid", event_valid, 1);
      chk("s5_code", event_code, 8'h55);
      step(2);
      key_down = 0;
      step(3);
      chk("s5_held", event_valid, 1);
      base = n_acc;
      event_ready = 1;
      step(1);
      chk("s5_one_acc", n_acc - base, 1);
      step(30);
      chk("s5_no_repeat", rise_q.size(), 1);
      chk("s5_idle_enabled", timer_enabled, 0);
      event_ready = 0;
      key_code = 8'h66;
      key_down = 1;
      step(1);
      chk("s6_valid", event_valid, 1);
      step(2);
      reset = 1;
      step(1);
      chk("s6_reset_valid", event_valid, 0);
      reset = 0;
      step(1);
      chk("s6_repress_valid", event_valid, 1);
      chk("s6_repress_code", event_code, 8'h66);
      event_ready = 1;
      key_down = 0;
      step(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
